// File: rtl/rotary_trim_pkg.sv
// Shared types and constants for the rotary trim encoder.
//   quad_state_t : debounced {A,B} quadrature state, Gray-ordered
//   TRIM_W       : width of the trim output
//   DIR_CW/CCW   : encoding of step_dir
package rotary_trim_pkg;

  localparam int TRIM_W = 9;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S11 = 2'b11,
    S10 = 2'b10
  } quad_state_t;

  // Clockwise successor in the Gray cycle S00 -> S01 -> S11 -> S10 -> S00.
  function automatic quad_state_t cw_next(input quad_state_t s);
    case (s)
      S00:     cw_next = S01;
      S01:     cw_next = S11;
      S11:     cw_next = S10;
      default: cw_next = S00;
    endcase
  endfunction

endpackage

// File: rtl/enc_debounce.sv
// Two-flop synchroniser followed by a consecutive-cycle debounce filter for
// one raw mechanical contact.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   raw_i      : raw asynchronous contact input
//   deb_o      : debounced, clk-synchronous level
// The counter only runs while the synchronised level differs from the
// debounced one; any return to agreement restarts it from zero.
module enc_debounce #(
  parameter int DEBOUNCE_CYCLES = 27000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic deb_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      // The cycle that would make the count reach DEBOUNCE_CYCLES accepts it.
      if (cnt_q == CNT_LAST) deb_d = sync2_q;
      else                   cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/rotary_trim_encoder.sv
// Quadrature rotary encoder to saturating speed-trim value.
// Ports:
//   clk, rst_n   : 27 MHz system clock, async active-low reset
//   enc_a, enc_b : raw encoder channels (asynchronous)
//   trim_clr     : synchronous clear of trim to TRIM_INIT
//   trim         : trim value, 0..TRIM_MAX
//   step_strobe  : one-cycle pulse per accepted detent
//   step_dir     : direction of last detent (1 = clockwise), held
//   quad_err     : one-cycle pulse on an illegal (two-bit) transition
// Optional feature macro: ROTARY_TRIM_ACCEL_EN enables detent acceleration.
//
// state | meaning (reference quadrature state ref_q)
// S00   | A=0 B=0, rest position after reset
// S01   | A=0 B=1, one CW edge past S00
// S11   | A=1 B=1
// S10   | A=1 B=0, one CCW edge past S00
module rotary_trim_encoder
  import rotary_trim_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 27000,
  parameter int STEPS_PER_DETENT = 4,
  parameter int TRIM_MAX         = 40,
  parameter int TRIM_INIT        = 0,
  parameter int FAST_WINDOW      = 1350000,
  parameter int FAST_STEP        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enc_a,
  input  logic              enc_b,
  input  logic              trim_clr,
  output logic [TRIM_W-1:0] trim,
  output logic              step_strobe,
  output logic              step_dir,
  output logic              quad_err
);

  localparam logic [TRIM_W-1:0] TRIM_MAX_V  = TRIM_W'(TRIM_MAX);
  localparam logic [TRIM_W-1:0] TRIM_INIT_V = TRIM_W'(TRIM_INIT);
  localparam logic signed [3:0] STEPS_POS   = 4'(STEPS_PER_DETENT);
  localparam logic signed [3:0] STEPS_NEG   = 4'(-STEPS_PER_DETENT);

  generate
    if (!(STEPS_PER_DETENT == 1 || STEPS_PER_DETENT == 2 || STEPS_PER_DETENT == 4) ||
        TRIM_MAX >= (1 << TRIM_W) || TRIM_INIT > TRIM_MAX ||
        FAST_STEP < 1 || FAST_WINDOW < 1) begin : g_cfg_bad
      $error("rotary_trim_encoder: illegal parameter combination");
    end
  endgenerate

  logic a_deb, b_deb;

  enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk), .rst_n(rst_n), .raw_i(enc_a), .deb_o(a_deb)
  );
  enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk), .rst_n(rst_n), .raw_i(enc_b), .deb_o(b_deb)
  );

  quad_state_t        cur_s, ref_q;
  logic signed [2:0]  acc_q, acc_d;
  logic signed [3:0]  acc_sum, delta;
  logic [TRIM_W-1:0]  trim_q, trim_d, step;
  logic [TRIM_W:0]    up_sum;
  logic               strobe_q, dir_q, dir_d, err_q;
  logic               fwd, bwd, illegal, det_cw, det_ccw, detent;

  assign cur_s = quad_state_t'({a_deb, b_deb});

`ifdef ROTARY_TRIM_ACCEL_EN
  localparam int IVL_W = $clog2(FAST_WINDOW + 1);
  localparam logic [IVL_W-1:0] IVL_SAT = IVL_W'(FAST_WINDOW);

  logic [IVL_W-1:0] ivl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ivl_q <= '0;
    else if (detent)           ivl_q <= '0;
    else if (ivl_q != IVL_SAT) ivl_q <= ivl_q + 1'b1;
  end

  // Fast only when the detent is quick and continues the previous direction.
  assign step = ((ivl_q < IVL_SAT) && ((det_cw ? DIR_CW : DIR_CCW) == dir_q))
                ? TRIM_W'(FAST_STEP) : TRIM_W'(1);
`else
  assign step = TRIM_W'(1);
`endif

  always_comb begin
    fwd     = (cur_s != ref_q) && (cur_s == cw_next(ref_q));
    bwd     = (cur_s != ref_q) && (ref_q == cw_next(cur_s));
    illegal = (cur_s != ref_q) && !fwd && !bwd;

    delta   = fwd ? 4'sd1 : (bwd ? -4'sd1 : 4'sd0);
    acc_sum = 4'(acc_q) + delta;
    det_cw  = (acc_sum == STEPS_POS);
    det_ccw = (acc_sum == STEPS_NEG);
    detent  = det_cw || det_ccw;

    // Emission and illegal transitions both restart the partial detent.
    acc_d = (illegal || detent) ? 3'sd0 : acc_sum[2:0];

    up_sum = {1'b0, trim_q} + {1'b0, step};
    trim_d = trim_q;
    dir_d  = dir_q;
    if (detent) begin
      dir_d = det_cw ? DIR_CW : DIR_CCW;
      if (det_cw) trim_d = (up_sum > {1'b0, TRIM_MAX_V}) ? TRIM_MAX_V : up_sum[TRIM_W-1:0];
      else        trim_d = (trim_q < step) ? '0 : trim_q - step;
    end
    if (trim_clr) trim_d = TRIM_INIT_V;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q    <= S00;
      acc_q    <= '0;
      trim_q   <= TRIM_INIT_V;
      strobe_q <= 1'b0;
      dir_q    <= DIR_CCW;
      err_q    <= 1'b0;
    end else begin
      ref_q    <= cur_s;
      acc_q    <= acc_d;
      trim_q   <= trim_d;
      strobe_q <= detent;
      dir_q    <= dir_d;
      err_q    <= illegal;
    end
  end

  assign trim        = trim_q;
  assign step_strobe = strobe_q;
  assign step_dir    = dir_q;
  assign quad_err    = err_q;

endmodule

// File: tb/tb_rotary_trim_encoder.sv
module tb_rotary_trim_encoder;

`ifdef ROTARY_TRIM_ACCEL_EN
  localparam int H = 60;   // phase hold long enough that table detents stay slow
`else
  localparam int H = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enc_a = 1'b0;
  logic       enc_b = 1'b0;
  logic       trim_clr = 1'b0;
  logic [8:0] trim;
  logic       step_strobe, step_dir, quad_err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_strobe = 0;
  int n_qerr = 0;

  rotary_trim_encoder #(
    .DEBOUNCE_CYCLES(4), .STEPS_PER_DETENT(4), .TRIM_MAX(40), .TRIM_INIT(0),
    .FAST_WINDOW(200), .FAST_STEP(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .trim_clr(trim_clr),
    .trim(trim), .step_strobe(step_strobe), .step_dir(step_dir), .quad_err(quad_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (step_strobe) n_strobe = n_strobe + 1;
    if (quad_err)    n_qerr   = n_qerr + 1;
  end

  typedef struct {
    bit cw;
    int count;
    int exp_trim;
    int exp_strobes;
    bit exp_dir;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic phase(input logic [1:0] ab, input int hold);
    enc_a = ab[1];
    enc_b = ab[0];
    repeat (hold) @(negedge clk);
  endtask

  task automatic cw_detent(input int hold);
    phase(2'b01, hold); phase(2'b11, hold); phase(2'b10, hold); phase(2'b00, hold);
  endtask

  task automatic ccw_detent(input int hold);
    phase(2'b10, hold); phase(2'b11, hold); phase(2'b01, hold); phase(2'b00, hold);
  endtask

  initial begin
    int s, q;

    vecs[0] = '{1'b1, 45, 40, 45, 1'b1};
    vecs[1] = '{1'b0,  1, 39,  1, 1'b0};
    vecs[2] = '{1'b0,  1, 38,  1, 1'b0};
    vecs[3] = '{1'b1,  2, 40,  2, 1'b1};
    vecs[4] = '{1'b0, 40,  0, 40, 1'b0};
    vecs[5] = '{1'b0,  2,  0,  2, 1'b0};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_trim",   trim, 0);
    check("rst_strobe", step_strobe, 0);
    check("rst_dir",    step_dir, 0);
    check("rst_qerr",   quad_err, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // one CW detent with exact strobe latency
    phase(2'b01, H); phase(2'b11, H); phase(2'b10, H);
    s = n_strobe;
    enc_a = 1'b0; enc_b = 1'b0;
    repeat (6) @(negedge clk);
    check("lat_strobe_early", step_strobe, 0);
    @(negedge clk);
    check("lat_strobe", step_strobe, 1);
    check("lat_dir", step_dir, 1);
    check("lat_trim", trim, 1);
    @(negedge clk);
    check("lat_strobe_once", step_strobe, 0);
    repeat (H) @(negedge clk);
    check("lat_strobe_count", n_strobe - s, 1);

    // 3-cycle glitch on A
    s = n_strobe; q = n_qerr;
    enc_a = 1'b1;
    repeat (3) @(negedge clk);
    enc_a = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_strobes", n_strobe - s, 0);
    check("glitch_qerr", n_qerr - q, 0);
    check("glitch_trim", trim, 1);

    // saturation table
    trim_clr = 1'b1;
    @(negedge clk);
    trim_clr = 1'b0;
    check("clr_trim", trim, 0);
    for (int i = 0; i < 6; i++) begin
      s = n_strobe;
      for (int k = 0; k < vecs[i].count; k++) begin
        if (vecs[i].cw) cw_detent(H);
        else            ccw_detent(H);
      end
      check($sformatf("tbl%0d_trim", i), trim, vecs[i].exp_trim);
      check($sformatf("tbl%0d_strobes", i), n_strobe - s, vecs[i].exp_strobes);
      check($sformatf("tbl%0d_dir", i), step_dir, vecs[i].exp_dir);
    end

    // both channels toggle together
    s = n_strobe; q = n_qerr;
    enc_a = 1'b1; enc_b = 1'b1;
    repeat (6) @(negedge clk);
    check("qerr_early", quad_err, 0);
    @(negedge clk);
    check("qerr_pulse", quad_err, 1);
    @(negedge clk);
    check("qerr_once", quad_err, 0);
    repeat (H) @(negedge clk);
    check("qerr_trim", trim, 0);
    check("qerr_no_strobe", n_strobe - s, 0);
    phase(2'b10, H); phase(2'b00, H); phase(2'b01, H); phase(2'b11, H);
    check("qerr_next_trim", trim, 1);
    check("qerr_next_strobe", n_strobe - s, 1);
    phase(2'b00, H);
    check("qerr_count", n_qerr - q, 2);
    check("qerr_back_trim", trim, 1);

    // trim_clr on the emission cycle
    for (int k = 0; k < 9; k++) cw_detent(H);
    check("pre_clr_trim", trim, 10);
    phase(2'b01, H); phase(2'b11, H); phase(2'b10, H);
    enc_a = 1'b0; enc_b = 1'b0;
    repeat (6) @(negedge clk);
    trim_clr = 1'b1;
    @(negedge clk);
    trim_clr = 1'b0;
    check("clr_det_strobe", step_strobe, 1);
    check("clr_det_trim", trim, 0);
    repeat (H) @(negedge clk);
    cw_detent(H);
    check("clr_det_after", trim, 1);

    // reset in the middle of a detent
    phase(2'b01, H); phase(2'b11, H);
    enc_a = 1'b0; enc_b = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_trim", trim, 0);
    check("mid_rst_dir", step_dir, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (H) @(negedge clk);
    s = n_strobe; q = n_qerr;
    phase(2'b01, H); phase(2'b11, H);
    check("mid_rst_partial", n_strobe - s, 0);
    phase(2'b10, H); phase(2'b00, H);
    check("mid_rst_strobes", n_strobe - s, 1);
    check("mid_rst_trim_after", trim, 1);
    check("mid_rst_qerr", n_qerr - q, 0);

`ifdef ROTARY_TRIM_ACCEL_EN
    trim_clr = 1'b1;
    @(negedge clk);
    trim_clr = 1'b0;
    repeat (250) @(negedge clk);
    cw_detent(25);
    check("acc_trim1", trim, 1);
    cw_detent(25);
    check("acc_trim5", trim, 5);
    cw_detent(25);
    check("acc_trim9", trim, 9);
    repeat (300) @(negedge clk);
    cw_detent(25);
    check("acc_slow", trim, 10);
    ccw_detent(25);
    check("acc_reverse", trim, 9);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
